// File: rtl/tx_ram_frame_reader.sv
// tx_ram_frame_reader
//   Read side of the TX distributed SDP RAM. Accepts a frame descriptor
//   (start address, length), reads the frame words out of the RAM and
//   presents them as a valid/ready stream with SOF/EOF markers. A small
//   skid FIFO absorbs the RAM read latency so backpressure never loses or
//   duplicates a word. A one-cycle frm_done pulse releases the buffer region.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   frm_valid/frm_ready             descriptor handshake (ready only in IDLE)
//   frm_start_addr, frm_len         descriptor: first word address, word count
//   ram_rd_addr                     registered RAM read address
//   ram_rd_data                     RAM data, RAM_LATENCY cycles after address
//   tx_data/tx_valid/tx_ready       outgoing word stream
//   tx_sof/tx_eof                   first/last word markers
//   tx_abort                        drop the remainder of the current frame
//   frm_done/frm_aborted            end-of-frame pulse and its abort qualifier
//   frm_count                       frames completed without abort
module tx_ram_frame_reader #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 64,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frm_valid,
  output logic                  frm_ready,
  input  logic [ADDR_WIDTH-1:0] frm_start_addr,
  input  logic [ADDR_WIDTH:0]   frm_len,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_sof,
  output logic                  tx_eof,
  input  logic                  tx_abort,
  output logic                  frm_done,
  output logic                  frm_aborted,
  output logic [15:0]           frm_count
);

  localparam int DEPTH = RAM_LATENCY + 2;
  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t state_q, state_d;

  logic [LEN_W-1:0]      len_q, issued_q, wr_idx_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  addr_valid_q, lat_valid_q;
  logic [1:0]            in_flight_q;
  logic [CNT_W-1:0]      occ_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  mem_sof  [DEPTH];
  logic                  mem_eof  [DEPTH];
  logic                  aborted_q;
  logic [15:0]           count_q;

  logic [LEN_W-1:0] len_sat;
  logic             accept, fifo_valid, pop, eof_pop, abort_now;
  logic             wr_en, issue_first, issue_stream, issue;
  logic [3:0]       credit;

  // Descriptor acceptance and length saturation; a zero-length frame issues
  // nothing, otherwise the first read address is registered on acceptance.
  always_comb begin
    accept      = (state_q == IDLE) && frm_valid;
    len_sat     = (frm_len > MAX_LEN) ? MAX_LEN : frm_len;
    issue_first = accept && (len_sat != '0);
  end

  // Stream-side handshakes. An abort that coincides with the EOF handshake
  // loses to it: the frame is then considered fully sent.
  always_comb begin
    fifo_valid = (occ_q != '0);
    pop        = fifo_valid && tx_ready;
    eof_pop    = pop && mem_eof[rd_ptr_q];
    abort_now  = (state_q == STREAM) && tx_abort && !eof_pop;
    wr_en      = (RAM_LATENCY == 0) ? addr_valid_q : lat_valid_q;
  end

  // Read credit: reads in flight plus words held, minus the word leaving now,
  // must stay below the FIFO depth so every returning word has a slot.
  always_comb begin
    credit       = 4'(in_flight_q) + 4'(occ_q) - 4'(pop);
    issue_stream = (state_q == STREAM) && !tx_abort &&
                   (issued_q < len_q) && (credit < 4'(DEPTH));
    issue        = issue_first || issue_stream;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (len_sat == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (eof_pop || tx_abort) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read issue, latency tracking and skid FIFO. An abort flushes the FIFO
  // and clears the in-flight markers so late RAM returns are never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      issued_q     <= '0;
      wr_idx_q     <= '0;
      rd_addr_q    <= '0;
      addr_valid_q <= 1'b0;
      lat_valid_q  <= 1'b0;
      in_flight_q  <= '0;
      occ_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      aborted_q    <= 1'b0;
      count_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_sof[i]  <= 1'b0;
        mem_eof[i]  <= 1'b0;
      end
    end else begin
      if (accept) begin
        len_q    <= len_sat;
        wr_idx_q <= '0;
        issued_q <= issue_first ? LEN_W'(1) : '0;
      end else if (issue_stream) begin
        issued_q <= issued_q + LEN_W'(1);
      end

      if (issue_first) begin
        rd_addr_q <= frm_start_addr;
      end else if (issue_stream) begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end

      if (abort_now) begin
        addr_valid_q <= 1'b0;
        lat_valid_q  <= 1'b0;
        in_flight_q  <= '0;
        occ_q        <= '0;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
      end else begin
        addr_valid_q <= issue;
        lat_valid_q  <= addr_valid_q;
        in_flight_q  <= in_flight_q + 2'(issue) - 2'(wr_en);
        occ_q        <= occ_q + CNT_W'(wr_en) - CNT_W'(pop);
        if (wr_en) begin
          mem_data[wr_ptr_q] <= ram_rd_data;
          mem_sof[wr_ptr_q]  <= (wr_idx_q == '0);
          mem_eof[wr_ptr_q]  <= (wr_idx_q == len_q - LEN_W'(1));
          wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
          wr_idx_q <= wr_idx_q + LEN_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
      end

      // Completion bookkeeping happens on the edge that enters DONE so the
      // updated count is already visible during the done pulse.
      if ((state_q != DONE) && (state_d == DONE)) begin
        aborted_q <= abort_now;
        if (!abort_now) begin
          count_q <= count_q + 16'd1;
        end
      end
    end
  end

  // frm_ready is masked by rst_n so it reads 0 while reset is held.
  assign frm_ready   = (state_q == IDLE) && rst_n;
  assign ram_rd_addr = rd_addr_q;
  assign tx_valid    = fifo_valid;
  assign tx_data     = fifo_valid ? mem_data[rd_ptr_q] : '0;
  assign tx_sof      = fifo_valid && mem_sof[rd_ptr_q];
  assign tx_eof      = fifo_valid && mem_eof[rd_ptr_q];
  assign frm_done    = (state_q == DONE);
  assign frm_aborted = (state_q == DONE) && aborted_q;
  assign frm_count   = count_q;

endmodule
